// File: rtl/expr_stream_checker.sv
// Byte-serial recognizer for +-*/ expressions with multi-digit numbers and bounded parentheses.
// Latency 1 cycle (outputs reflect the post-update state); no backpressure, every in_valid cycle is consumed.
module expr_stream_checker #(
  parameter int MAX_DEPTH  = 4,
  parameter int MAX_DIGITS = 4,
  parameter int CNT_W      = 8,
  parameter int DEP_W      = $clog2(MAX_DEPTH+1)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [7:0]       in,
  output logic             out,
  output logic             err,
  output logic [DEP_W-1:0] depth,
  output logic [CNT_W-1:0] op_cnt
);

  localparam int DIG_W = $clog2(MAX_DIGITS+1);
  localparam logic [DEP_W-1:0] DEPTH_MAX = DEP_W'(MAX_DEPTH);
  localparam logic [DIG_W-1:0] DIG_MAX   = DIG_W'(MAX_DIGITS);

  localparam logic [3:0] S_EXP = 4'b0001;
  localparam logic [3:0] S_NUM = 4'b0010;
  localparam logic [3:0] S_CLS = 4'b0100;
  localparam logic [3:0] S_ERR = 4'b1000;

  logic [3:0]       state, nstate;
  logic [DIG_W-1:0] dig, ndig;
  logic [DEP_W-1:0] ndepth;
  logic [CNT_W-1:0] ncnt, cnt_sat;
  logic             is_dig, is_op, is_lp, is_rp;

  assign is_dig  = (in >= 8'h30) && (in <= 8'h39);
  assign is_op   = (in == 8'h2B) || (in == 8'h2D) || (in == 8'h2A) || (in == 8'h2F);
  assign is_lp   = (in == 8'h28);
  assign is_rp   = (in == 8'h29);
  assign cnt_sat = (op_cnt == '1) ? op_cnt : op_cnt + 1'b1;

  always_comb begin
    nstate = state;
    ndepth = depth;
    ndig   = dig;
    ncnt   = op_cnt;
    case (state)
      S_EXP: begin
        if (is_dig) begin
          nstate = S_NUM;
          ndig   = DIG_W'(1);
        end else if (is_lp && depth < DEPTH_MAX) begin
          ndepth = depth + 1'b1;
        end else begin
          nstate = S_ERR;
        end
      end
      S_NUM: begin
        if (is_dig && dig < DIG_MAX) begin
          ndig = dig + 1'b1;
        end else if (is_op) begin
          nstate = S_EXP;
          ncnt   = cnt_sat;
          ndig   = '0;
        end else if (is_rp && depth != '0) begin
          nstate = S_CLS;
          ndepth = depth - 1'b1;
        end else begin
          nstate = S_ERR;
        end
      end
      S_CLS: begin
        if (is_op) begin
          nstate = S_EXP;
          ncnt   = cnt_sat;
        end else if (is_rp && depth != '0) begin
          ndepth = depth - 1'b1;
        end else begin
          nstate = S_ERR;
        end
      end
      S_ERR: nstate = S_ERR;
      // Corrupted one-hot encodings restart the term search, keeping the counters.
      default: nstate = S_EXP;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state  <= S_EXP;
      depth  <= '0;
      dig    <= '0;
      op_cnt <= '0;
      out    <= 1'b0;
      err    <= 1'b0;
    end else if (in_valid) begin
      state  <= nstate;
      depth  <= ndepth;
      dig    <= ndig;
      op_cnt <= ncnt;
      out    <= ((nstate == S_NUM) || (nstate == S_CLS)) && (ndepth == '0);
      err    <= (nstate == S_ERR);
    end
  end

endmodule

// File: tb/tb_expr_stream_checker.sv
// Directed vector bench for expr_stream_checker with default parameters.
module tb_expr_stream_checker;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in = 8'h00;
  logic       out, err;
  logic [2:0] depth;
  logic [7:0] op_cnt;

  int checks = 0;
  int errors = 0;

  expr_stream_checker dut (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in(in),
    .out(out), .err(err), .depth(depth), .op_cnt(op_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       pre_clr;
    logic [7:0] ch;
    logic       e_out;
    logic       e_err;
    int         e_depth;
    int         e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic c, input logic [7:0] ch, input logic eo, input logic ee,
                     input int ed, input int ec);
    vec_t v;
    v.pre_clr = c; v.ch = ch; v.e_out = eo; v.e_err = ee; v.e_depth = ed; v.e_cnt = ec;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp_v);
    end
  endtask

  task automatic chk_all(input string nm, input logic eo, input logic ee, input int ed, input int ec);
    chk({nm, ".out"}, int'(out), int'(eo));
    chk({nm, ".err"}, int'(err), int'(ee));
    chk({nm, ".depth"}, int'(depth), ed);
    chk({nm, ".op_cnt"}, int'(op_cnt), ec);
  endtask

  task automatic do_clr();
    in_valid = 1'b0;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  task automatic feed(input logic v, input logic [7:0] ch);
    in_valid = v;
    in = ch;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    // 12+34
    add(1, "1", 1, 0, 0, 0); add(0, "2", 1, 0, 0, 0); add(0, "+", 0, 0, 0, 1);
    add(0, "3", 1, 0, 0, 1); add(0, "4", 1, 0, 0, 1);
    // ((7*8))
    add(1, "(", 0, 0, 1, 0); add(0, "(", 0, 0, 2, 0); add(0, "7", 0, 0, 2, 0);
    add(0, "*", 0, 0, 2, 1); add(0, "8", 0, 0, 2, 1); add(0, ")", 0, 0, 1, 1);
    add(0, ")", 1, 0, 0, 1);
    // overlong number, then sticky error
    add(1, "1", 1, 0, 0, 0); add(0, "2", 1, 0, 0, 0); add(0, "3", 1, 0, 0, 0);
    add(0, "4", 1, 0, 0, 0); add(0, "5", 0, 1, 0, 0); add(0, "+", 0, 1, 0, 0);
    add(0, "6", 0, 1, 0, 0);
    // nesting limit
    add(1, "(", 0, 0, 1, 0); add(0, "(", 0, 0, 2, 0); add(0, "(", 0, 0, 3, 0);
    add(0, "(", 0, 0, 4, 0); add(0, "(", 0, 1, 4, 0); add(0, ")", 0, 1, 4, 0);
    // unmatched ")", empty parens, leading operator
    add(1, "3", 1, 0, 0, 0); add(0, ")", 0, 1, 0, 0);
    add(1, "(", 0, 0, 1, 0); add(0, ")", 0, 1, 1, 0);
    add(1, "+", 0, 1, 0, 0);
    // leading zeros and division by zero
    add(1, "0", 1, 0, 0, 0); add(0, "0", 1, 0, 0, 0); add(0, "7", 1, 0, 0, 0);
    add(0, "/", 0, 0, 0, 1); add(0, "0", 1, 0, 0, 1);
    // double operator, space, implicit multiplication
    add(1, "1", 1, 0, 0, 0); add(0, "-", 0, 0, 0, 1); add(0, "*", 0, 1, 0, 1);
    add(1, "1", 1, 0, 0, 0); add(0, " ", 0, 1, 0, 0);
    add(1, "(", 0, 0, 1, 0); add(0, "1", 0, 0, 1, 0); add(0, ")", 1, 0, 0, 0);
    add(0, "2", 0, 1, 0, 0);

    do_clr();
    chk_all("reset", 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].pre_clr) do_clr();
      feed(1'b1, vecs[i].ch);
      chk_all($sformatf("vec%0d", i), vecs[i].e_out, vecs[i].e_err, vecs[i].e_depth, vecs[i].e_cnt);
    end

    // Qualifier hold, then asynchronous clear mid-stream
    do_clr();
    feed(1'b1, "9"); feed(1'b1, "+"); feed(1'b1, "9");
    chk_all("pre_hold", 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      feed(1'b0, "x");
      chk_all($sformatf("hold%0d", i), 1, 0, 0, 1);
    end
    #2;
    clr = 1'b1;
    #1;
    chk_all("async_clr", 0, 0, 0, 0);
    in_valid = 1'b1;
    in = "(";
    @(posedge clk); #1;
    chk_all("clr_blocks_input", 0, 0, 0, 0);
    clr = 1'b0;
    in_valid = 1'b0;
    feed(1'b1, "5");
    chk_all("after_clr", 1, 0, 0, 0);

    // Operator counter saturation
    do_clr();
    for (int i = 0; i < 255; i++) begin
      feed(1'b1, "1");
      feed(1'b1, "+");
    end
    chk_all("cnt_255", 0, 0, 0, 255);
    feed(1'b1, "1");
    feed(1'b1, "*");
    chk_all("cnt_sat", 0, 0, 0, 255);
    feed(1'b1, "2");
    chk_all("cnt_sat_end", 1, 0, 0, 255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
